// File: rtl/decode_stage.sv
// Registered instruction-decode stage: splits an instruction into opcode, register and offset fields.
// A main register M drives the outputs and a skid register S absorbs one extra word under back-pressure.
module decode_stage #(
    parameter int OPCODE_W = 4,
    parameter int REG_W    = 5,
    parameter int OFFSET_W = 13,
    parameter int INSTR_W  = 32,
    parameter int DATA_W   = 32,
    parameter int PC_W     = 32,
    parameter bit SIGN_EXT = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INSTR_W-1:0]  in_instr,
    input  logic [PC_W-1:0]     in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OPCODE_W-1:0] out_opcode,
    output logic [REG_W-1:0]    out_reg_d,
    output logic [REG_W-1:0]    out_reg_a,
    output logic [REG_W-1:0]    out_reg_b,
    output logic [OFFSET_W-1:0] out_offset,
    output logic [DATA_W-1:0]   out_imm,
    output logic [PC_W-1:0]     out_pc
);

    localparam int RD_LSB  = OPCODE_W;
    localparam int RA_LSB  = RD_LSB + REG_W;
    localparam int RB_LSB  = RA_LSB + REG_W;
    localparam int OFF_LSB = INSTR_W - OFFSET_W;

    typedef struct packed {
        logic [PC_W-1:0]     pc;
        logic [DATA_W-1:0]   imm;
        logic [OFFSET_W-1:0] offset;
        logic [REG_W-1:0]    reg_b;
        logic [REG_W-1:0]    reg_a;
        logic [REG_W-1:0]    reg_d;
        logic [OPCODE_W-1:0] opcode;
    } dec_t;

    dec_t              in_dec;
    dec_t              m_data_reg;
    dec_t              s_data_reg;
    logic              m_valid_reg;
    logic              s_valid_reg;
    logic [DATA_W-1:0] imm_ext;
    logic              in_xfer;
    logic              m_drain;

    // Offset occupies the low bits of the immediate; the rest are filled by the extension rule.
    assign imm_ext[OFFSET_W-1:0] = in_instr[INSTR_W-1:OFF_LSB];

    generate
        for (genvar gi = OFFSET_W; gi < DATA_W; gi++) begin : g_ext
            assign imm_ext[gi] = SIGN_EXT ? in_instr[INSTR_W-1] : 1'b0;
        end
    endgenerate

    assign in_dec.opcode = in_instr[OPCODE_W-1:0];
    assign in_dec.reg_d  = in_instr[RD_LSB +: REG_W];
    assign in_dec.reg_a  = in_instr[RA_LSB +: REG_W];
    assign in_dec.reg_b  = in_instr[RB_LSB +: REG_W];
    assign in_dec.offset = in_instr[INSTR_W-1:OFF_LSB];
    assign in_dec.imm    = imm_ext;
    assign in_dec.pc     = in_pc;

    // Ready depends only on the skid occupancy, so out_ready never reaches in_ready.
    assign in_ready = reset_n && !s_valid_reg;
    assign in_xfer  = in_valid && in_ready;
    assign m_drain  = !m_valid_reg || out_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            m_valid_reg <= 1'b0;
            s_valid_reg <= 1'b0;
            m_data_reg  <= '0;
            s_data_reg  <= '0;
        end else if (flush) begin
            m_valid_reg <= 1'b0;
            s_valid_reg <= 1'b0;
        end else if (m_drain) begin
            if (s_valid_reg) begin
                // The skid entry is older than anything at the input, so it goes first.
                m_data_reg  <= s_data_reg;
                m_valid_reg <= 1'b1;
                s_valid_reg <= 1'b0;
            end else begin
                m_valid_reg <= in_xfer;
                if (in_xfer) begin
                    m_data_reg <= in_dec;
                end
            end
        end else if (in_xfer) begin
            s_data_reg  <= in_dec;
            s_valid_reg <= 1'b1;
        end
    end

    assign out_valid  = m_valid_reg;
    assign out_opcode = m_data_reg.opcode;
    assign out_reg_d  = m_data_reg.reg_d;
    assign out_reg_a  = m_data_reg.reg_a;
    assign out_reg_b  = m_data_reg.reg_b;
    assign out_offset = m_data_reg.offset;
    assign out_imm    = m_data_reg.imm;
    assign out_pc     = m_data_reg.pc;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed steps plus random traffic checked against a queue-based model
// of the stage contents; a second instance with zero extension shares the same stimulus.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_ready;

    logic        in_ready,   in_ready_z;
    logic        out_valid,  out_valid_z;
    logic [3:0]  out_opcode, out_opcode_z;
    logic [4:0]  out_reg_d,  out_reg_d_z;
    logic [4:0]  out_reg_a,  out_reg_a_z;
    logic [4:0]  out_reg_b,  out_reg_b_z;
    logic [12:0] out_offset, out_offset_z;
    logic [31:0] out_imm,    out_imm_z;
    logic [31:0] out_pc,     out_pc_z;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] w;
        logic [31:0] pc;
    } item_t;

    item_t q[$];

    always #5 clk = ~clk;

    decode_stage #(.SIGN_EXT(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_reg_d(out_reg_d), .out_reg_a(out_reg_a),
        .out_reg_b(out_reg_b), .out_offset(out_offset), .out_imm(out_imm), .out_pc(out_pc)
    );

    decode_stage #(.SIGN_EXT(1'b0)) dut_z (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_z), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid_z), .out_ready(out_ready),
        .out_opcode(out_opcode_z), .out_reg_d(out_reg_d_z), .out_reg_a(out_reg_a_z),
        .out_reg_b(out_reg_b_z), .out_offset(out_offset_z), .out_imm(out_imm_z), .out_pc(out_pc_z)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference decode from the field layout using shifts and masks.
    task automatic check_fields(input item_t it);
        logic [31:0] off;
        logic [31:0] imm_s;
        off   = it.w >> 19;
        imm_s = (off >= 32'd4096) ? off + 32'hFFFF_E000 : off;
        chk("opcode", {60'd0, out_opcode}, it.w & 32'hF);
        chk("reg_d",  {59'd0, out_reg_d},  (it.w >> 4) & 32'h1F);
        chk("reg_a",  {59'd0, out_reg_a},  (it.w >> 9) & 32'h1F);
        chk("reg_b",  {59'd0, out_reg_b},  (it.w >> 14) & 32'h1F);
        chk("offset", {51'd0, out_offset}, off);
        chk("imm_sext", {32'd0, out_imm},  imm_s);
        chk("imm_zext", {32'd0, out_imm_z}, off);
        chk("pc",     {32'd0, out_pc},     it.pc);
    endtask

    // One clock cycle: drive inputs, check outputs against the model, clock, update the model.
    task automatic cyc(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit ordy, input bit fl, input bit rn, output bit acc);
        bit ir_exp, ov_exp, out_x;
        item_t it;
        in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl; reset_n = rn;
        #1;
        ir_exp = rn && (q.size() < 2);
        ov_exp = (q.size() > 0);
        chk("in_ready",    {63'd0, in_ready},    {63'd0, ir_exp});
        chk("out_valid",   {63'd0, out_valid},   {63'd0, ov_exp});
        chk("out_valid_z", {63'd0, out_valid_z}, {63'd0, ov_exp});
        if (ov_exp && out_valid === 1'b1) check_fields(q[0]);
        acc   = v && ir_exp;
        out_x = ov_exp && ordy;
        @(posedge clk);
        #1;
        if (!rn || fl) begin
            q.delete();
        end else begin
            if (out_x) void'(q.pop_front());
            if (acc) begin
                it.w = ins; it.pc = pc;
                q.push_back(it);
            end
        end
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] pc, input bit ordy);
        bit acc = 1'b0;
        for (int k = 0; k < 8 && !acc; k++) cyc(1'b1, ins, pc, ordy, 1'b0, 1'b1, acc);
        chk("accept_in_bound", {63'd0, acc}, 64'd1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, acc);
    endtask

    initial begin
        bit acc;
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready",  {63'd0, in_ready},  64'd0);
        chk("rst_imm",       {32'd0, out_imm},   64'd0);
        chk("rst_pc",        {32'd0, out_pc},    64'd0);

        // First instruction after reset, one cycle latency.
        cyc(1'b1, 32'h0000_8610, 32'h0, 1'b1, 1'b0, 1'b1, acc);
        chk("t1_valid", {63'd0, out_valid}, 64'd1);
        chk("t1_reg_d", {59'd0, out_reg_d}, 64'h01);
        chk("t1_reg_a", {59'd0, out_reg_a}, 64'h03);
        chk("t1_reg_b", {59'd0, out_reg_b}, 64'h02);
        chk("t1_imm",   {32'd0, out_imm},   64'h0);

        // Back-to-back stream.
        cyc(1'b1, 32'h0001_C670, 32'h4, 1'b1, 1'b0, 1'b1, acc);
        chk("t2_reg_d", {59'd0, out_reg_d}, 64'h07);
        cyc(1'b1, 32'h0030_8193, 32'h8, 1'b1, 1'b0, 1'b1, acc);
        chk("t3_opcode", {60'd0, out_opcode}, 64'h3);
        chk("t3_reg_d",  {59'd0, out_reg_d},  64'h19);
        chk("t3_imm",    {32'd0, out_imm},    64'h6);

        // Extension boundary: all-ones offset.
        cyc(1'b1, 32'hFFF8_0000, 32'hC, 1'b1, 1'b0, 1'b1, acc);
        chk("ext_offset", {51'd0, out_offset}, 64'h1FFF);
        chk("ext_sext",   {32'd0, out_imm},    64'hFFFF_FFFF);
        chk("ext_zext",   {32'd0, out_imm_z},  64'h0000_1FFF);
        idle(2);

        // Back-pressure: three words against a stalled sink.
        cyc(1'b1, 32'h1111_1111, 32'h100, 1'b0, 1'b0, 1'b1, acc);
        cyc(1'b1, 32'h2222_2222, 32'h104, 1'b0, 1'b0, 1'b1, acc);
        chk("bp_full_in_ready", {63'd0, in_ready}, 64'd0);
        for (int k = 0; k < 3; k++) cyc(1'b1, 32'h3333_3333, 32'h108, 1'b0, 1'b0, 1'b1, acc);
        send(32'h3333_3333, 32'h108, 1'b1);
        idle(4);

        // Flush with both registers full and a word offered in the same cycle.
        cyc(1'b1, 32'hAAAA_0001, 32'h200, 1'b0, 1'b0, 1'b1, acc);
        cyc(1'b1, 32'hAAAA_0002, 32'h204, 1'b0, 1'b0, 1'b1, acc);
        cyc(1'b1, 32'hAAAA_0003, 32'h208, 1'b0, 1'b1, 1'b1, acc);
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_in_ready",  {63'd0, in_ready},  64'd1);
        send(32'h5555_0005, 32'h20C, 1'b1);
        idle(2);

        // Reset in the middle of traffic.
        cyc(1'b1, 32'hBBBB_0001, 32'h300, 1'b0, 1'b0, 1'b1, acc);
        cyc(1'b1, 32'hBBBB_0002, 32'h304, 1'b0, 1'b0, 1'b1, acc);
        cyc(1'b1, 32'hBBBB_0003, 32'h308, 1'b1, 1'b0, 1'b0, acc);
        chk("mrst_in_ready", {63'd0, in_ready},   64'd0);
        chk("mrst_opcode",   {60'd0, out_opcode}, 64'd0);
        chk("mrst_offset",   {51'd0, out_offset}, 64'd0);
        chk("mrst_pc",       {32'd0, out_pc},     64'd0);
        chk("mrst_imm_z",    {32'd0, out_imm_z},  64'd0);
        cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, acc);
        chk("mrst_release_ready", {63'd0, in_ready}, 64'd1);

        // Random traffic with occasional flush.
        for (int k = 0; k < 400; k++) begin
            cyc(1'($urandom_range(0, 3) != 0), $urandom(), 32'h1000 + 32'(k * 4),
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0), 1'b1, acc);
        end
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised instruction-decode pipeline stage with valid/ready handshakes on both sides.
- Splits each instruction word into opcode, reg_d, reg_a, reg_b and offset fields, and extends the offset to DATA_W bits, sign- or zero-extended per SIGN_EXT.
- A 2-entry skid buffer gives full throughput under back-pressure.
- Sits between instruction fetch and register-file read; a synchronous flush discards in-flight instructions on a branch.

Parameters:
- OPCODE_W, 4, opcode field width (instr[OPCODE_W-1:0]).
- REG_W, 5, width of each register-index field.
- OFFSET_W, 13, offset field width (top bits of the instruction).
- INSTR_W, 32, instruction width; must equal OPCODE_W+3*REG_W+OFFSET_W.
- DATA_W, 32, width of extended offset; must be >= OFFSET_W.
- PC_W, 32, width of the PC carried alongside the instruction.
- SIGN_EXT, 1, 1 = sign-extend offset, 0 = zero-extend.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  synchronous reset, active low.
- flush  in  1  discard all buffered instructions.
- in_valid  in  1  instruction/pc valid.
- in_ready  out  1  stage can accept an instruction.
- in_instr  in  INSTR_W  instruction word.
- in_pc  in  PC_W  PC of instruction.
- out_valid  out  1  decoded fields valid.
- out_ready  in  1  downstream accepts.
- out_opcode  out  OPCODE_W  instr[OPCODE_W-1:0].
- out_reg_d  out  REG_W  next REG_W bits above opcode.
- out_reg_a  out  REG_W  next REG_W bits.
- out_reg_b  out  REG_W  next REG_W bits.
- out_offset  out  OFFSET_W  instr[INSTR_W-1:INSTR_W-OFFSET_W], raw.
- out_imm  out  DATA_W  offset extended per SIGN_EXT.
- out_pc  out  PC_W  PC of the decoded instruction.

Behaviour:
- Field layout (defaults):
  - opcode [3:0], reg_d [8:4], reg_a [13:9], reg_b [18:14], offset [31:19].
  - Positions derive from the parameters in the same order.
- Storage:
  - Main output register: M, drives the out_* ports.
  - Skid register: S.
  - Each has a valid bit; both are cleared on reset.
- Reset:
  - While reset_n = 0 at a clock edge: M.valid = 0, S.valid = 0, all out_* data = 0.
  - in_ready = 0 while reset_n is low; in_ready = 1 in the first cycle after release.
- Handshake:
  - in_ready = !S.valid (registered state, no combinational path from out_ready).
  - Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
  - out_* data are held stable while out_valid && !out_ready.
- Latency: an instruction accepted at edge N drives out_valid with decoded fields after edge N (1 cycle) when M was empty or drained at N.
- Per-edge update, no flush:
  - If M is empty or drained: M <= S if S.valid, else M <= the incoming transfer; S is cleared if it moved to M.
  - If M is held (valid, not drained) and an input transfer occurs: S <= input.
  - Order is always preserved: S is older than any new input.
- Simultaneous events: with S.valid, M drained and in_valid, in_ready = 0, so the input is not taken and S moves to M.
- Full condition: M and S both valid gives in_ready = 0; no overwrite is possible.
- Throughput: 1 instruction/cycle while out_ready stays high.
- Decode is computed on entry; M and S hold decoded fields, not raw words.
- Extension:
  - SIGN_EXT=1: out_imm = {{(DATA_W-OFFSET_W){offset[MSB]}}, offset}.
  - SIGN_EXT=0: upper bits are 0.
- Flush:
  - At the edge: M.valid = 0 and S.valid = 0; any input transfer in that cycle is discarded.
  - in_ready = 1 on the next cycle.
  - A flush has no effect on held data values other than the valid bits.
- Reset asserted mid-stream: the same as flush, plus the data registers are zeroed.

Test Plan:
- Reset then in_instr=0x00008610, pc=0x0 -> next cycle out_valid=1, opcode=0, reg_d=01, reg_a=03, reg_b=02, offset=0000, imm=0x00000000.
- Stream 0x0001C670, 0x00308193 with out_ready=1 -> back-to-back outputs:
  - first: opcode 0, reg_d 07, reg_a 03, reg_b 07, offset 0.
  - second: opcode 3, reg_d 19, reg_a 00, reg_b 02, offset 0006, imm 0x00000006.
- 0xFFF80000:
  - SIGN_EXT=1 -> offset 0x1FFF, imm 0xFFFFFFFF.
  - Second instance with SIGN_EXT=0 -> imm 0x00001FFF.
- Back-pressure:
  - Hold out_ready=0 and drive 3 instructions -> in_ready falls after the 2nd is accepted, the 3rd is held.
  - Release out_ready -> all 3 emerge in order, no loss or duplication; out_* stable while stalled.
- Flush with M and S both full plus in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1; no flushed instruction ever appears.
- Assert reset_n=0 for 1 cycle mid-stream -> out_valid=0 and outputs zero after the edge, in_ready=0 during reset, then 1.
